adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
- Write-side sequencer for the ADC sample FIFO. Runs in the wr_clk domain, between the ADC sample stream and the async FIFO write port.
- Arms on software start and waits for a selectable trigger. It then captures a decimated, counted burst of samples into the FIFO.
- Reports overflow, completion and FIFO threshold events through a sticky interrupt status.

Parameters:
DATA_W, 10, ADC sample / FIFO data width
CNT_W, 16, width of the sample-count, decimation and frame counters

Ports:
rst  in  1  asynchronous active-high reset
wr_clk  in  1  clock (FIFO write clock domain)
cfg_start  in  1  one-cycle start pulse
cfg_stop  in  1  one-cycle abort pulse
cfg_mode  in  1  0 = single burst, 1 = continuous (re-arm after each burst)
cfg_trig_sel  in  2  0 = immediate, 1 = ext_trig rising edge, 2 = level crossing, 3 = reserved (treated as 0)
cfg_trig_level  in  DATA_W  level-trigger threshold (unsigned)
cfg_decim  in  CNT_W  keep 1 of every cfg_decim+1 valid samples
cfg_num_samples  in  CNT_W  samples per burst; 0 = unlimited
adc_valid  in  1  sample strobe, at most one per cycle
adc_data  in  DATA_W  sample
ext_trig  in  1  asynchronous external trigger
fifo_full  in  1  FIFO full flag
fifo_half  in  1  FIFO half-threshold flag
fifo_thr_full  in  1  FIFO full-threshold flag
fifo_wr_en  out  1  registered FIFO write enable
fifo_din  out  DATA_W  registered FIFO write data
busy  out  1  high in ARMED or CAPTURE
sample_cnt  out  CNT_W  writes issued in the current burst
frame_cnt  out  CNT_W  completed bursts since start (wraps)
irq_status  out  4  sticky status: [0] half, [1] thr_full, [2] done, [3] ovf
irq_clr  in  4  write-1-to-clear for irq_status
irq  out  1  OR of irq_status

Behaviour:
- Reset (rst asynchronous, active-high; clock wr_clk):
  - state = IDLE.
  - All outputs = 0.
  - All counters, synchronisers and edge registers = 0.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE:
  - cfg_start with trig_sel 0/3 -> CAPTURE.
  - cfg_start with trig_sel 1/2 -> ARMED.
  - On start: sample_cnt = 0, frame_cnt = 0.
- ARMED, waiting for the trigger event -> CAPTURE:
  - sel 1: ext_trig passes through a 2-FF synchroniser; event = synced 0->1.
  - sel 2: event = adc_valid, adc_data >= cfg_trig_level, and previous valid sample < cfg_trig_level. The previous-sample register clears on entering ARMED.
  - The triggering sample itself is not captured.
- CAPTURE:
  - Decimation counter is cleared on entry, so the first adc_valid is kept.
  - Each adc_valid: if decim_cnt == 0, the sample is accepted, else it is skipped.
  - decim_cnt increments on every adc_valid and wraps to 0 after reaching cfg_decim. cfg_decim = 0 keeps every sample.
  - Accepted sample: next cycle fifo_wr_en = 1, fifo_din = adc_data, sample_cnt += 1. Latency is exactly 1 cycle.
  - When the accepted sample brings sample_cnt to cfg_num_samples (nonzero), the same edge -> DONE.
- DONE, one cycle:
  - frame_cnt += 1; irq_status[2] set.
  - cfg_mode 0 -> IDLE.
  - cfg_mode 1 -> sample_cnt = 0, then ARMED (sel 1/2) or CAPTURE (sel 0/3).
- fifo_wr_en is high for exactly one cycle per accepted sample. fifo_din holds its value when fifo_wr_en = 0.
- Overflow:
  - fifo_wr_en = 1 with fifo_full = 1 in the same cycle means the FIFO rejects the write. irq_status[3] is set.
  - The sample still counts in sample_cnt. The burst continues.
- cfg_stop:
  - Any state -> IDLE at the next edge. frame_cnt is not incremented; done is not flagged.
  - A write already registered still completes.
  - cfg_start and cfg_stop in the same cycle: stop wins.
  - cfg_start while busy is ignored.
- irq_status bits [0] and [1]:
  - Set on a 0->1 edge of fifo_half / fifo_thr_full, using a one-cycle-delayed copy. These flags are already in the wr_clk domain.
- irq_status clear:
  - irq_clr[n] clears bit n.
  - A set event in the same cycle wins over clear.
- Config inputs must be held stable while busy. They are sampled live.
- Counters wrap modulo 2^CNT_W.
- Reset asserted mid-burst aborts immediately. No write is issued after reset.

Test Plan:
1. Reset, trig_sel 0, decim 0, num 4, mode 0; 6 consecutive adc_valid with data 1..6, start pulse -> fifo_wr_en 4 cycles carrying 1,2,3,4, each one cycle after its valid; DONE; irq_status = 4'b0100; busy low; frame_cnt = 1.
2. decim 2, num 3, data 10..18 -> writes 10, 13, 16; sample_cnt = 3.
3. trig_sel 2, level 100; samples 50, 120, 90, 150, 160, num 2 -> trigger on 120; writes 90, 150; no trigger on 150 while ARMED repeats not needed. Then trig_sel 1: ext_trig pulse -> CAPTURE 3 cycles after the rising edge (2 sync + edge).
4. fifo_full held 1 during a 3-sample burst -> 3 write strobes; irq_status[3] = 1; irq = 1; irq_clr = 4'b1000 -> bit clears; simultaneous overflow and clear -> bit stays 1.
5. mode 1, num 2, sel 0, 6 samples -> frame_cnt = 3; continuous writes; then cfg_stop mid-burst -> IDLE next cycle, frame_cnt stays 3; start+stop same cycle -> stays IDLE.
6. rst asserted during CAPTURE -> fifo_wr_en, busy, counters and irq_status 0 immediately; fifo_half 0->1 after reset -> irq_status[0] = 1.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// Write-side sequencer for the ADC sample FIFO: arms on start, waits for a
// selectable trigger, then pushes a decimated, counted burst into the FIFO.
module adc_capture_ctrl #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              rst,
  input  logic              wr_clk,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_mode,
  input  logic [1:0]        cfg_trig_sel,
  input  logic [DATA_W-1:0] cfg_trig_level,
  input  logic [CNT_W-1:0]  cfg_decim,
  input  logic [CNT_W-1:0]  cfg_num_samples,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              ext_trig,
  input  logic              fifo_full,
  input  logic              fifo_half,
  input  logic              fifo_thr_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [3:0]        irq_status,
  input  logic [3:0]        irq_clr,
  output logic              irq,
  output logic [1:0]        dbg_state
);

  // Handshake: adc_valid is a push-only strobe (no ready); a sample is taken
  // in the cycle it is high or lost. fifo_wr_en is likewise push-only and the
  // FIFO signals rejection through fifo_full in the same cycle.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, state_nxt;

  logic              ext_s1, ext_s2, ext_s3;
  logic [DATA_W-1:0] prev_data;
  logic [CNT_W-1:0]  decim_cnt;
  logic              half_d, thr_d;

  logic              sel_ext, sel_lvl, sel_armed;
  logic              ext_event, lvl_event, trig_event;
  logic [CNT_W-1:0]  sample_cnt_inc;
  logic              accept, done_evt, clr_counts;
  logic              enter_armed, enter_capture;
  logic [3:0]        irq_set;

  assign sel_ext   = (cfg_trig_sel == 2'd1);
  assign sel_lvl   = (cfg_trig_sel == 2'd2);
  assign sel_armed = sel_ext | sel_lvl;

  assign ext_event  = ext_s2 & ~ext_s3;
  assign lvl_event  = adc_valid && (adc_data >= cfg_trig_level) && (prev_data < cfg_trig_level);
  assign trig_event = sel_ext ? ext_event : lvl_event;

  assign sample_cnt_inc = sample_cnt + CNT_ONE;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    done_evt      = 1'b0;
    clr_counts    = 1'b0;
    enter_armed   = 1'b0;
    enter_capture = 1'b0;
    if (cfg_stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            clr_counts = 1'b1;
            if (sel_armed) begin
              state_nxt   = ARMED;
              enter_armed = 1'b1;
            end else begin
              state_nxt     = CAPTURE;
              enter_capture = 1'b1;
            end
          end
        end
        ARMED: begin
          if (trig_event) begin
            state_nxt     = CAPTURE;
            enter_capture = 1'b1;
          end
        end
        CAPTURE: begin
          if (adc_valid && (decim_cnt == '0)) begin
            accept = 1'b1;
            if ((cfg_num_samples != '0) && (sample_cnt_inc == cfg_num_samples))
              state_nxt = DONE;
          end
        end
        DONE: begin
          done_evt = 1'b1;
          if (!cfg_mode) begin
            state_nxt = IDLE;
          end else if (sel_armed) begin
            state_nxt   = ARMED;
            enter_armed = 1'b1;
          end else begin
            state_nxt     = CAPTURE;
            enter_capture = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Overflow looks at the write currently on the port, so it lands one edge later.
  assign irq_set = {fifo_wr_en & fifo_full, done_evt,
                    fifo_thr_full & ~thr_d, fifo_half & ~half_d};

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      sample_cnt <= '0;
      frame_cnt  <= '0;
      irq_status <= '0;
      decim_cnt  <= '0;
      prev_data  <= '0;
      ext_s1     <= 1'b0;
      ext_s2     <= 1'b0;
      ext_s3     <= 1'b0;
      half_d     <= 1'b0;
      thr_d      <= 1'b0;
    end else begin
      fifo_wr_en <= accept;
      if (accept) begin
        fifo_din   <= adc_data;
        sample_cnt <= sample_cnt_inc;
      end
      if (clr_counts) begin
        sample_cnt <= '0;
        frame_cnt  <= '0;
      end
      if (done_evt) begin
        frame_cnt <= frame_cnt + CNT_ONE;
        if (cfg_mode) sample_cnt <= '0;
      end

      if (enter_capture)
        decim_cnt <= '0;
      else if ((state == CAPTURE) && adc_valid && !cfg_stop)
        decim_cnt <= (decim_cnt == cfg_decim) ? '0 : decim_cnt + CNT_ONE;

      if (enter_armed)
        prev_data <= '0;
      else if ((state == ARMED) && adc_valid)
        prev_data <= adc_data;

      ext_s1 <= ext_trig;
      ext_s2 <= ext_s1;
      ext_s3 <= ext_s2;
      half_d <= fifo_half;
      thr_d  <= fifo_thr_full;

      irq_status <= (irq_status & ~irq_clr) | irq_set;
    end
  end

  assign busy      = (state == ARMED) || (state == CAPTURE);
  assign irq       = |irq_status;
  assign dbg_state = state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: linear steps, immediate assertions,
// hand-computed expectations.
module tb_adc_capture_ctrl;

  localparam int DATA_W = 10;
  localparam int CNT_W  = 16;

  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_DONE = 3;

  logic              rst, wr_clk;
  logic              cfg_start, cfg_stop, cfg_mode;
  logic [1:0]        cfg_trig_sel;
  logic [DATA_W-1:0] cfg_trig_level;
  logic [CNT_W-1:0]  cfg_decim, cfg_num_samples;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic              ext_trig, fifo_full, fifo_half, fifo_thr_full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_din;
  logic              busy;
  logic [CNT_W-1:0]  sample_cnt, frame_cnt;
  logic [3:0]        irq_status, irq_clr;
  logic              irq;
  logic [1:0]        dbg_state;

  int vectors = 0;
  int miscompares = 0;

  int t3_data [5] = '{50, 120, 90, 150, 160};
  int t3_wr   [5] = '{0, 0, 1, 1, 0};
  int t3_din  [5] = '{16, 16, 90, 150, 150};
  int t3_st   [5] = '{S_ARMED, S_CAPTURE, S_CAPTURE, S_DONE, S_IDLE};
  int t5_v    [9] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};

  adc_capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .rst(rst), .wr_clk(wr_clk),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_mode(cfg_mode),
    .cfg_trig_sel(cfg_trig_sel), .cfg_trig_level(cfg_trig_level),
    .cfg_decim(cfg_decim), .cfg_num_samples(cfg_num_samples),
    .adc_valid(adc_valid), .adc_data(adc_data), .ext_trig(ext_trig),
    .fifo_full(fifo_full), .fifo_half(fifo_half), .fifo_thr_full(fifo_thr_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy),
    .sample_cnt(sample_cnt), .frame_cnt(frame_cnt),
    .irq_status(irq_status), .irq_clr(irq_clr), .irq(irq), .dbg_state(dbg_state)
  );

  // clock / reset
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // driver tasks
  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic clear_irq();
    irq_clr = 4'hf;
    tick();
    irq_clr = 4'h0;
  endtask

  initial begin
    rst = 1'b1; cfg_start = 0; cfg_stop = 0; cfg_mode = 0; cfg_trig_sel = 0;
    cfg_trig_level = '0; cfg_decim = '0; cfg_num_samples = '0;
    adc_valid = 0; adc_data = '0; ext_trig = 0; fifo_full = 0; fifo_half = 0;
    fifo_thr_full = 0; irq_clr = 4'h0;

    // 1: reset values, then basic burst of 4
    tick(); tick();
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_din", 32'(fifo_din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_scnt", 32'(sample_cnt), 0);
    chk("rst_fcnt", 32'(frame_cnt), 0);
    chk("rst_irq_status", 32'(irq_status), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_state", 32'(dbg_state), S_IDLE);
    rst = 1'b0;
    tick();

    cfg_num_samples = 16'd4;
    pulse_start();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_state", 32'(dbg_state), S_CAPTURE);
    for (int i = 1; i <= 6; i++) begin
      adc_valid = 1'b1; adc_data = 10'(i);
      tick();
      chk($sformatf("t1_wr_%0d", i), 32'(fifo_wr_en), (i <= 4) ? 1 : 0);
      chk($sformatf("t1_din_%0d", i), 32'(fifo_din), (i <= 4) ? i : 4);
    end
    adc_valid = 1'b0;
    chk("t1_irq_status", 32'(irq_status), 32'h4);
    chk("t1_irq", 32'(irq), 1);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_fcnt", 32'(frame_cnt), 1);
    chk("t1_scnt", 32'(sample_cnt), 4);
    clear_irq();
    chk("t1_irq_cleared", 32'(irq_status), 0);

    // 2: decimation by 3
    cfg_decim = 16'd2; cfg_num_samples = 16'd3;
    pulse_start();
    for (int k = 10; k <= 18; k++) begin
      adc_valid = 1'b1; adc_data = 10'(k);
      tick();
      chk($sformatf("t2_wr_%0d", k), 32'(fifo_wr_en), ((k <= 16) && ((k - 10) % 3 == 0)) ? 1 : 0);
      chk($sformatf("t2_din_%0d", k), 32'(fifo_din), (k > 16) ? 16 : 10 + ((k - 10) / 3) * 3);
    end
    adc_valid = 1'b0;
    chk("t2_scnt", 32'(sample_cnt), 3);
    chk("t2_fcnt", 32'(frame_cnt), 1);
    clear_irq();

    // 3a: level trigger, triggering sample not captured
    cfg_decim = '0; cfg_num_samples = 16'd2; cfg_trig_sel = 2'd2; cfg_trig_level = 10'd100;
    pulse_start();
    chk("t3_armed", 32'(dbg_state), S_ARMED);
    chk("t3_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      adc_valid = 1'b1; adc_data = 10'(t3_data[i]);
      tick();
      chk($sformatf("t3_wr_%0d", i), 32'(fifo_wr_en), 32'(t3_wr[i]));
      chk($sformatf("t3_din_%0d", i), 32'(fifo_din), 32'(t3_din[i]));
      chk($sformatf("t3_state_%0d", i), 32'(dbg_state), 32'(t3_st[i]));
    end
    adc_valid = 1'b0;
    chk("t3_fcnt", 32'(frame_cnt), 1);
    clear_irq();

    // 3b: external trigger through the synchroniser
    cfg_trig_sel = 2'd1;
    pulse_start();
    chk("t3e_armed", 32'(dbg_state), S_ARMED);
    chk("t3e_fcnt_clr", 32'(frame_cnt), 0);
    ext_trig = 1'b1;
    tick();
    chk("t3e_sync1", 32'(dbg_state), S_ARMED);
    tick();
    chk("t3e_sync2", 32'(dbg_state), S_ARMED);
    tick();
    chk("t3e_capture", 32'(dbg_state), S_CAPTURE);
    ext_trig = 1'b0; cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    chk("t3e_stop_state", 32'(dbg_state), S_IDLE);
    chk("t3e_stop_fcnt", 32'(frame_cnt), 0);
    chk("t3e_stop_irq", 32'(irq_status), 0);

    // 4: overflow
    cfg_trig_sel = 2'd0; cfg_num_samples = 16'd3; fifo_full = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      adc_valid = 1'b1; adc_data = 10'(21 + i);
      tick();
      chk($sformatf("t4_wr_%0d", i), 32'(fifo_wr_en), 1);
      chk($sformatf("t4_din_%0d", i), 32'(fifo_din), 32'(21 + i));
      chk($sformatf("t4_ovf_%0d", i), 32'(irq_status[3]), (i == 0) ? 0 : 1);
    end
    adc_valid = 1'b0;
    tick();
    chk("t4_wr_end", 32'(fifo_wr_en), 0);
    chk("t4_scnt", 32'(sample_cnt), 3);
    chk("t4_irq_status", 32'(irq_status), 32'hc);
    chk("t4_irq", 32'(irq), 1);
    fifo_full = 1'b0; irq_clr = 4'b1000;
    tick();
    irq_clr = 4'b0000;
    chk("t4_clr_ovf", 32'(irq_status), 32'h4);
    irq_clr = 4'b0100;
    tick();
    irq_clr = 4'b0000;
    chk("t4_clr_done", 32'(irq_status), 0);
    chk("t4_irq_low", 32'(irq), 0);

    cfg_num_samples = 16'd2; fifo_full = 1'b1;
    pulse_start();
    adc_valid = 1'b1; adc_data = 10'd31;
    tick();
    adc_data = 10'd32;
    tick();
    chk("t4b_ovf_set", 32'(irq_status[3]), 1);
    adc_valid = 1'b0; irq_clr = 4'b1000;
    tick();
    irq_clr = 4'b0000; fifo_full = 1'b0;
    chk("t4b_set_wins", 32'(irq_status[3]), 1);
    clear_irq();
    chk("t4b_cleared", 32'(irq_status), 0);

    // 5: continuous mode, then stop
    cfg_mode = 1'b1; cfg_num_samples = 16'd2;
    pulse_start();
    begin
      int d = 41;
      for (int i = 0; i < 9; i++) begin
        adc_valid = 1'(t5_v[i]); adc_data = 10'(d);
        tick();
        chk($sformatf("t5_wr_%0d", i), 32'(fifo_wr_en), 32'(t5_v[i]));
        if (t5_v[i] == 1) begin
          chk($sformatf("t5_din_%0d", i), 32'(fifo_din), 32'(d));
          d++;
        end
      end
    end
    chk("t5_fcnt", 32'(frame_cnt), 3);
    chk("t5_scnt", 32'(sample_cnt), 0);
    chk("t5_state", 32'(dbg_state), S_CAPTURE);
    adc_valid = 1'b1; adc_data = 10'd47; irq_clr = 4'b0100;
    tick();
    irq_clr = 4'b0000;
    chk("t5_wr47", 32'(fifo_wr_en), 1);
    chk("t5_irq_clr", 32'(irq_status), 0);
    adc_data = 10'd48; cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0; adc_valid = 1'b0;
    chk("t5_stop_state", 32'(dbg_state), S_IDLE);
    chk("t5_stop_wr", 32'(fifo_wr_en), 0);
    chk("t5_stop_fcnt", 32'(frame_cnt), 3);
    chk("t5_stop_scnt", 32'(sample_cnt), 1);
    chk("t5_stop_irq", 32'(irq_status), 0);
    cfg_start = 1'b1; cfg_stop = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    chk("t5_ss_state", 32'(dbg_state), S_IDLE);
    chk("t5_ss_busy", 32'(busy), 0);
    chk("t5_ss_fcnt", 32'(frame_cnt), 3);
    chk("t5_ss_scnt", 32'(sample_cnt), 1);

    // 6: asynchronous reset mid-burst, then a half-flag edge
    cfg_mode = 1'b0; cfg_num_samples = '0;
    pulse_start();
    adc_valid = 1'b1; adc_data = 10'd55; fifo_thr_full = 1'b1;
    tick();
    chk("t6_wr", 32'(fifo_wr_en), 1);
    chk("t6_thr_irq", 32'(irq_status), 32'h2);
    adc_valid = 1'b0; fifo_thr_full = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_wr", 32'(fifo_wr_en), 0);
    chk("t6_rst_din", 32'(fifo_din), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_scnt", 32'(sample_cnt), 0);
    chk("t6_rst_fcnt", 32'(frame_cnt), 0);
    chk("t6_rst_irq", 32'(irq_status), 0);
    tick();
    chk("t6_rst_hold_wr", 32'(fifo_wr_en), 0);
    rst = 1'b0; fifo_half = 1'b1;
    tick();
    chk("t6_half_irq", 32'(irq_status), 32'h1);
    chk("t6_irq", 32'(irq), 1);
    chk("t6_wr_after", 32'(fifo_wr_en), 0);
    chk("t6_state", 32'(dbg_state), S_IDLE);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
